// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU main control FSM and control decode
// Walks IF/ID/EXE/MEM/WB and decodes datapath enables and selects from state, opcode and ALU flags.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegData,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc
);

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_LD  = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] DST_RA = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RD = 2'b10;

  logic [2:0] state_q, state_d;

  // Instruction classes; unknown opcodes fall through to halt.
  logic       is_alu, is_imm, is_addi, is_sll;
  logic       is_ls, is_lw, is_branch;
  logic       is_j, is_jal, is_jr;
  logic [2:0] alu_op_sel;
  logic       br_taken;

  always_comb begin
    is_alu     = 1'b0;
    is_imm     = 1'b0;
    is_addi    = 1'b0;
    is_sll     = 1'b0;
    is_ls      = 1'b0;
    is_lw      = 1'b0;
    is_branch  = 1'b0;
    is_j       = 1'b0;
    is_jal     = 1'b0;
    is_jr      = 1'b0;
    alu_op_sel = ALU_ADD;
    br_taken   = 1'b0;
    case (opcode)
      OP_ADD:  begin is_alu = 1'b1; alu_op_sel = ALU_ADD; end
      OP_SUB:  begin is_alu = 1'b1; alu_op_sel = ALU_SUB; end
      OP_ADDI: begin is_alu = 1'b1; is_imm = 1'b1; is_addi = 1'b1; alu_op_sel = ALU_ADD; end
      OP_AND:  begin is_alu = 1'b1; alu_op_sel = ALU_AND; end
      OP_ORI:  begin is_alu = 1'b1; is_imm = 1'b1; alu_op_sel = ALU_OR; end
      OP_SLL:  begin is_alu = 1'b1; is_sll = 1'b1; alu_op_sel = ALU_SLL; end
      OP_SLT:  begin is_alu = 1'b1; alu_op_sel = ALU_SLT; end
      OP_SW:   is_ls = 1'b1;
      OP_LW:   begin is_ls = 1'b1; is_lw = 1'b1; end
      OP_BEQ:  begin is_branch = 1'b1; br_taken = zero; end
      OP_BNE:  begin is_branch = 1'b1; br_taken = ~zero; end
      OP_BLTZ: begin is_branch = 1'b1; br_taken = sign; end
      OP_J:    is_j = 1'b1;
      OP_JR:   is_jr = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_branch)   state_d = S_EXE_BR;
        else if (is_ls)  state_d = S_EXE_LS;
        else if (is_alu) state_d = S_EXE_AL;
        else             state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
      default:  state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  logic pc_wre_c, ir_wre_c, reg_wre_c, m_rd_c, m_wr_c;

  always_comb begin
    pc_wre_c  = 1'b0;
    ir_wre_c  = 1'b0;
    InsMemRW  = 1'b0;
    reg_wre_c = 1'b0;
    RegDst    = DST_RA;
    WrRegData = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    m_rd_c    = 1'b0;
    m_wr_c    = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = PC_SEQ;
    case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        ir_wre_c = 1'b1;
      end
      S_ID: begin
        if (is_j || is_jal) begin
          pc_wre_c = 1'b1;
          PCSrc    = PC_JUMP;
        end else if (is_jr) begin
          pc_wre_c = 1'b1;
          PCSrc    = PC_REG;
        end
        if (is_jal) begin
          reg_wre_c = 1'b1;
          RegDst    = DST_RA;
          WrRegData = 1'b0;
        end
      end
      // WB_AL keeps the EXE_AL ALU setup so the result stays valid through write-back.
      S_EXE_AL, S_WB_AL: begin
        ALUOp   = alu_op_sel;
        ALUSrcB = is_imm;
        ExtSel  = is_addi;
        ALUSrcA = is_sll;
        if (state_q == S_WB_AL) begin
          reg_wre_c = 1'b1;
          WrRegData = 1'b1;
          DBDataSrc = 1'b0;
          pc_wre_c  = 1'b1;
          PCSrc     = PC_SEQ;
          RegDst    = is_imm ? DST_RT : DST_RD;
        end
      end
      S_EXE_BR: begin
        ALUOp    = ALU_SUB;
        ALUSrcB  = 1'b0;
        ExtSel   = 1'b1;
        pc_wre_c = 1'b1;
        PCSrc    = br_taken ? PC_BRANCH : PC_SEQ;
      end
      S_EXE_LS, S_MEM: begin
        ALUOp   = ALU_ADD;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        if (state_q == S_MEM) begin
          if (is_lw) begin
            m_rd_c = 1'b1;
          end else begin
            m_wr_c   = 1'b1;
            pc_wre_c = 1'b1;
            PCSrc    = PC_SEQ;
          end
        end
      end
      S_WB_LD: begin
        m_rd_c    = 1'b1;
        DBDataSrc = 1'b1;
        WrRegData = 1'b1;
        RegDst    = DST_RT;
        reg_wre_c = 1'b1;
        pc_wre_c  = 1'b1;
        PCSrc     = PC_SEQ;
      end
      default: ;
    endcase
  end

  // Write enables are gated by reset directly so an abort never commits a partial write.
  assign PCWre = pc_wre_c  & rst_n;
  assign IRWre = ir_wre_c  & rst_n;
  assign RegWre = reg_wre_c & rst_n;
  assign mRD   = m_rd_c    & rst_n;
  assign mWR   = m_wr_c    & rst_n;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
// Each row drives one cycle; its expected control word is queued and checked on the falling edge.
module tb_multicycle_ctrl;

  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_LS = 3'b010, ST_MEM = 3'b011;
  localparam logic [2:0] ST_WBLD = 3'b100, ST_BR = 3'b101, ST_AL = 3'b110, ST_WBAL = 3'b111;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, AND_ = 6'b010001;
  localparam logic [5:0] ORI = 6'b010010, SLL = 6'b011000, SLT = 6'b100110, SW = 6'b110000;
  localparam logic [5:0] LW = 6'b110001, BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
  localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;
  localparam logic [5:0] ILL = 6'b101010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, zero, sign;
  logic [5:0] opcode;
  logic [2:0] state, ALUOp;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegData, ALUSrcA, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegData(WrRegData), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
  );

  logic [20:0] act;
  assign act = {state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegData, ALUSrcA, ALUSrcB,
                ALUOp, ExtSel, mRD, mWR, DBDataSrc, PCSrc};

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        s;
    logic [20:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [20:0] sb_q[$];
  logic [20:0] mon_exp;
  int          n_tests = 0;
  int          n_fail = 0;
  int          mon_idx = 0;

  function automatic logic [20:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                     input logic imr, input logic rw, input logic [1:0] rd,
                                     input logic wrd, input logic sa, input logic sb,
                                     input logic [2:0] aop, input logic ext, input logic mrd,
                                     input logic mwr, input logic dbs, input logic [1:0] pcs);
    return {st, pcw, irw, imr, rw, rd, wrd, sa, sb, aop, ext, mrd, mwr, dbs, pcs};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic add_row(input logic [5:0] op, input logic z, input logic s, input logic [20:0] e);
    vec_t v;
    v.op = op; v.z = z; v.s = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    opcode = v.op;
    zero   = v.z;
    sign   = v.s;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_exp = sb_q.pop_front();
      check($sformatf("row%0d st%0d", mon_idx, mon_exp[20:18]), {11'd0, act}, {11'd0, mon_exp});
      mon_idx++;
    end
  end

  logic [20:0] w_if, w_id, w_rst, w_ls, w_br;
  vec_t        tmp;

  initial begin
    rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; sign = 1'b0;
    w_if  = mk(ST_IF, 0, 1, 1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00);
    w_rst = mk(ST_IF, 0, 0, 1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00);
    w_id  = mk(ST_ID, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00);
    w_ls  = mk(ST_LS, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 0, 0, 0, 2'b00);
    w_br  = mk(ST_BR, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 1, 0, 0, 0, 2'b00);

    // ALU ops; the IF row carries a foreign opcode that must not matter
    add_row(HALT, 1, 1, w_if); add_row(ADD, 1, 0, w_id);
    add_row(ADD, 0, 1, mk(ST_AL, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
    add_row(ADD, 1, 1, mk(ST_WBAL, 1, 0, 0, 1, 2'b10, 1, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
    add_row(ILL, 0, 0, w_if); add_row(ADDI, 0, 0, w_id);
    add_row(ADDI, 1, 0, mk(ST_AL, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 0, 0, 0, 2'b00));
    add_row(ADDI, 0, 1, mk(ST_WBAL, 1, 0, 0, 1, 2'b01, 1, 0, 1, 3'b000, 1, 0, 0, 0, 2'b00));
    add_row(J, 0, 0, w_if); add_row(SLL, 0, 0, w_id);
    add_row(SLL, 0, 0, mk(ST_AL, 0, 0, 0, 0, 2'b00, 0, 1, 0, 3'b101, 0, 0, 0, 0, 2'b00));
    add_row(SLL, 0, 0, mk(ST_WBAL, 1, 0, 0, 1, 2'b10, 1, 1, 0, 3'b101, 0, 0, 0, 0, 2'b00));
    add_row(SUB, 0, 0, w_if); add_row(SUB, 0, 0, w_id);
    add_row(SUB, 1, 1, mk(ST_AL, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b001, 0, 0, 0, 0, 2'b00));
    add_row(SUB, 0, 0, mk(ST_WBAL, 1, 0, 0, 1, 2'b10, 1, 0, 0, 3'b001, 0, 0, 0, 0, 2'b00));
    add_row(AND_, 0, 0, w_if); add_row(AND_, 0, 0, w_id);
    add_row(AND_, 0, 0, mk(ST_AL, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00));
    add_row(AND_, 0, 0, mk(ST_WBAL, 1, 0, 0, 1, 2'b10, 1, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00));
    add_row(ORI, 0, 0, w_if); add_row(ORI, 0, 0, w_id);
    add_row(ORI, 0, 0, mk(ST_AL, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b011, 0, 0, 0, 0, 2'b00));
    add_row(ORI, 0, 0, mk(ST_WBAL, 1, 0, 0, 1, 2'b01, 1, 0, 1, 3'b011, 0, 0, 0, 0, 2'b00));
    add_row(SLT, 0, 0, w_if); add_row(SLT, 0, 0, w_id);
    add_row(SLT, 0, 0, mk(ST_AL, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b100, 0, 0, 0, 0, 2'b00));
    add_row(SLT, 0, 0, mk(ST_WBAL, 1, 0, 0, 1, 2'b10, 1, 0, 0, 3'b100, 0, 0, 0, 0, 2'b00));
    // memory
    add_row(LW, 0, 0, w_if); add_row(LW, 0, 0, w_id); add_row(LW, 1, 1, w_ls);
    add_row(LW, 0, 0, mk(ST_MEM, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 1, 0, 0, 2'b00));
    add_row(LW, 0, 0, mk(ST_WBLD, 1, 0, 0, 1, 2'b01, 1, 0, 0, 3'b000, 0, 1, 0, 1, 2'b00));
    add_row(SW, 0, 0, w_if); add_row(SW, 0, 0, w_id); add_row(SW, 0, 0, w_ls);
    add_row(SW, 1, 1, mk(ST_MEM, 1, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 0, 1, 0, 2'b00));
    // branches: taken / not taken for each condition
    add_row(BEQ, 0, 0, w_if); add_row(BEQ, 0, 0, w_id); add_row(BEQ, 1, 0, w_br | 21'd1);
    add_row(BEQ, 0, 0, w_if); add_row(BEQ, 1, 0, w_id); add_row(BEQ, 0, 1, w_br);
    add_row(BNE, 0, 0, w_if); add_row(BNE, 0, 0, w_id); add_row(BNE, 0, 0, w_br | 21'd1);
    add_row(BNE, 0, 0, w_if); add_row(BNE, 0, 0, w_id); add_row(BNE, 1, 1, w_br);
    add_row(BLTZ, 0, 0, w_if); add_row(BLTZ, 0, 0, w_id); add_row(BLTZ, 0, 1, w_br | 21'd1);
    add_row(BLTZ, 0, 0, w_if); add_row(BLTZ, 0, 0, w_id); add_row(BLTZ, 1, 0, w_br);
    // jumps resolve in ID
    add_row(J, 0, 0, w_if);
    add_row(J, 0, 0, mk(ST_ID, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b11));
    add_row(JAL, 0, 0, w_if);
    add_row(JAL, 0, 0, mk(ST_ID, 1, 0, 0, 1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b11));
    add_row(JR, 0, 0, w_if);
    add_row(JR, 0, 0, mk(ST_ID, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b10));
    // halt and an illegal opcode spin IF/ID with PCWre low for 20 cycles each
    for (int i = 0; i < 10; i++) begin
      add_row(6'($urandom), 1'($urandom), 1'($urandom), w_if);
      add_row(HALT, 1'($urandom), 1'($urandom), w_id);
    end
    for (int i = 0; i < 10; i++) begin
      add_row(6'($urandom), 1'($urandom), 1'($urandom), w_if);
      add_row(ILL, 1'($urandom), 1'($urandom), w_id);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {11'd0, act}, {11'd0, w_rst});
    @(posedge clk);
    #1;
    check("reset_hold", {11'd0, act}, {11'd0, w_rst});
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // reset while an sw is in MEM must kill mWR at once
    tmp.op = SW; tmp.z = 0; tmp.s = 0;
    tmp.exp = w_if; apply(tmp);
    tmp.exp = w_id; apply(tmp);
    tmp.exp = w_ls; apply(tmp);
    sb_q.push_back(mk(ST_MEM, 1, 0, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 0, 1, 0, 2'b00));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mwr", {31'd0, mWR}, 32'd0);
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_word", {11'd0, act}, {11'd0, w_rst});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tmp.op = HALT; tmp.exp = w_if; apply(tmp);
    tmp.exp = w_id; apply(tmp);

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle CPU. It sequences every instruction through the fetch, decode, execute, memory and write-back stages. From the current state, the instruction opcode and the ALU flags it drives all datapath write enables and multiplexer selects: PC, IR, register file, ALU, data memory and write-back path. The state register advances on the rising edge, so decoded controls are stable before the negedge-clocked datapath registers (the operand latch and similar) capture values.

## Interface
- No parameters; the opcode map and state encoding below are fixed.
- clk  in  1  system clock; the state register updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26] of the current instruction; stable from the ID state onward.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result bit 31.
- state  out  3  current state, for debug.
- PCWre  out  1  PC write enable.
- IRWre  out  1  IR write enable.
- InsMemRW  out  1  instruction memory read.
- RegWre  out  1  register file write enable.
- RegDst  out  2  write register select: 00 = $31, 01 = rt, 10 = rd.
- WrRegData  out  1  write-data select: 0 = PC+4 (jal), 1 = write-back path.
- ALUSrcA  out  1  ALU A select: 0 = rs, 1 = sa (shift amount).
- ALUSrcB  out  1  ALU B select: 0 = rt, 1 = extended immediate.
- ALUOp  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sll.
- ExtSel  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- DBDataSrc  out  1  write-back source: 0 = ALU, 1 = memory.
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target.

## Operation
- Opcodes: add 000000, sub 000001, addi 000010, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
- Any other opcode is treated as halt.
- State encoding: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Transitions:
  - IF goes to ID.
  - ID goes to IF for j, jal, jr and halt; to EXE_BR for beq, bne and bltz; to EXE_LS for sw and lw; otherwise to EXE_AL.
  - EXE_AL goes to WB_AL, then WB_AL goes to IF.
  - EXE_BR goes to IF.
  - EXE_LS goes to MEM. MEM goes to IF for sw and to WB_LD for lw. WB_LD goes to IF.
- Controls are a combinational decode of the registered state and opcode. Every control not listed for a state below is 0.
- IF: InsMemRW = 1, IRWre = 1.
- ID:
  - j: PCWre = 1, PCSrc = 11.
  - jal: PCWre = 1, PCSrc = 11, RegWre = 1, RegDst = 00, WrRegData = 0.
  - jr: PCWre = 1, PCSrc = 10.
  - halt: PCWre = 0, so the same halt word is refetched forever.
- EXE_AL:
  - ALUOp per instruction.
  - ALUSrcB = 1 for addi and ori; ExtSel = 1 for addi only.
  - ALUSrcA = 1 for sll.
- WB_AL: RegWre = 1, WrRegData = 1, DBDataSrc = 0, PCWre = 1, PCSrc = 00. RegDst = 01 for addi and ori, 10 otherwise. ALUOp and the ALU selects are held from EXE_AL.
- EXE_BR: ALUOp = 001, ALUSrcB = 0, ExtSel = 1, PCWre = 1.
  - PCSrc = 01 when taken, else 00.
  - Taken condition: beq when zero = 1; bne when zero = 0; bltz when sign = 1 (B operand is rt, which is $0 by encoding).
- EXE_LS: ALUOp = 000, ALUSrcB = 1, ExtSel = 1.
- MEM: ALU controls are held from EXE_LS.
  - sw: mWR = 1, PCWre = 1, PCSrc = 00.
  - lw: mRD = 1.
- WB_LD: mRD = 1, DBDataSrc = 1, WrRegData = 1, RegDst = 01, RegWre = 1, PCWre = 1, PCSrc = 00.
- Exactly one PCWre pulse per non-halt instruction. RegWre and mWR are never asserted in the same cycle.

## Timing
- While rst_n = 0: state = IF (000), and PCWre, IRWre, RegWre, mWR and mRD are forced to 0. All other outputs follow the IF decode.
- The first rising edge after reset release moves the FSM from IF to ID.
- Reset asserted mid-instruction aborts immediately. Partial results are never written, because the write enables drop asynchronously.
- Instruction latency in cycles: j, jal and jr take 2; beq, bne and bltz take 3; sw takes 4; add, sub, addi, and, ori, sll and slt take 4; lw takes 5.
- zero and sign are sampled only in EXE_BR. They must settle within the EXE_BR cycle.
- opcode changes outside ID through WB (i.e. during IF) must not affect the state sequence.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles → state = 000 and all write enables = 0. After release, IF then ID; IRWre = 1 only in IF.
- Arithmetic sequence: add, then addi, then sll. Expected per instruction:
  - add: states IF, ID, EXE_AL, WB_AL; ALUOp = 000; RegDst = 10 in WB_AL; one PCWre pulse.
  - addi: ALUSrcB = 1 and ExtSel = 1.
  - sll: ALUSrcA = 1 and ALUOp = 101.
- Loads and stores: lw visits IF, ID, EXE_LS, MEM, WB_LD, with mRD = 1 in MEM and WB_LD and RegWre = 1 only in WB_LD. sw ends at MEM with mWR = 1 and PCWre = 1, then returns to IF.
- Branches:
  - beq with zero = 1 → PCSrc = 01; with zero = 0 → PCSrc = 00.
  - bne is the inverse of beq.
  - bltz with sign = 1 → PCSrc = 01.
  - Each branch takes 3 cycles.
- Jumps: jal in ID → RegWre = 1, RegDst = 00, WrRegData = 0, PCSrc = 11. jr → PCSrc = 10. Both take 2 cycles.
- Halt and illegal opcode: opcode 111111 or 101010 → IF/ID repeats, PCWre stays 0 for 20 cycles. Pulsing rst_n low while in MEM of an sw → mWR drops asynchronously and state = 000.
